f_sweep_ctrl: RTL and testbench

- Sequential sweeper that sits beside the 4-input combinational function block f.
- Upstream role: drives f's inputs a,b,c,d through all 16 combinations in ascending order.
- Downstream role: samples f's output s for each combination and builds a 16-bit truth-table map and a ones count.
- Compares the map against an expected table and reports pass/fail with a start/done handshake.
- Used for self-checking of f in simulation and as an on-chip function checker.

---
 rtl/f_sweep_pkg.sv | 15 +
 rtl/f_sweep_ctrl.sv | 112 +++++++++++
 tb/tb_f_sweep_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/f_sweep_pkg.sv
// Shared definitions for the f truth-table sweeper: FSM state encoding,
// vector count and the golden truth table of f.
package f_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int unsigned N_VEC     = 16;
  localparam logic [15:0] F_REF_MAP = 16'h212F;

endpackage

// File: rtl/f_sweep_ctrl.sv
// Drives f through all 16 input vectors, captures its truth table and ones
// count, and compares the table against an expected map.
module f_sweep_ctrl
  import f_sweep_pkg::*;
#(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned N_VEC  = f_sweep_pkg::N_VEC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [3:0]  abcd,
  input  logic        s_in,
  input  logic [15:0] expect_map,
  output logic        busy,
  output logic        done,
  output logic [15:0] map,
  output logic [4:0]  ones,
  output logic        match
);

  localparam logic [3:0] LAST_IDX   = 4'(N_VEC - 1);
  localparam logic [3:0] SETTLE_LD  = 4'(SETTLE);
  localparam state_t     FIRST_STEP = (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  abcd_q, abcd_d;
  logic        busy_q, busy_d;
  logic [15:0] map_q, map_d;
  logic [4:0]  ones_q, ones_d;
  logic        match_q, match_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      abcd_q  <= '0;
      busy_q  <= 1'b0;
      map_q   <= '0;
      ones_q  <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      abcd_q  <= abcd_d;
      busy_q  <= busy_d;
      map_q   <= map_d;
      ones_q  <= ones_d;
      match_q <= match_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    abcd_d  = abcd_q;
    busy_d  = busy_q;
    map_d   = map_q;
    ones_d  = ones_q;
    match_d = match_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = '0;
          abcd_d  = '0;
          map_d   = '0;
          ones_d  = '0;
          match_d = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = SETTLE_LD;
          state_d = FIRST_STEP;
        end
      end
      ST_SETTLE: begin
        // Counter is loaded with SETTLE, so leaving at 1 spends exactly SETTLE cycles here.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        map_d[idx_q] = s_in;
        ones_d       = ones_q + {4'b0000, s_in};
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          abcd_d  = idx_q + 4'd1;
          cnt_d   = SETTLE_LD;
          state_d = FIRST_STEP;
        end
      end
      ST_DONE: begin
        match_d = (map_q == expect_map);
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign abcd  = abcd_q;
  assign busy  = busy_q;
  assign done  = (state_q == ST_DONE);
  assign map   = map_q;
  assign ones  = ones_q;
  assign match = match_q;

endmodule

// File: tb/tb_f_sweep_ctrl.sv
// Bench for f_sweep_ctrl: f is modelled as a truth-table lookup on abcd, and
// every sweep is checked cycle by cycle against timing derived from SETTLE.
module tb_f_sweep_ctrl;
  import f_sweep_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start0, start1;
  logic [3:0]  abcd0, abcd1;
  logic        s0, s1;
  logic [15:0] tbl0, tbl1, exp0, exp1;
  logic        glitch0, junk0;
  logic        busy0, busy1, done0, done1, match0, match1;
  logic [15:0] map0, map1;
  logic [4:0]  ones0, ones1;

  int errors = 0;
  int checks = 0;

  // f with optional interference on s during settle cycles
  assign s0 = glitch0 ? junk0 : tbl0[abcd0];
  assign s1 = tbl1[abcd1];

  f_sweep_ctrl #(.SETTLE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abcd(abcd0), .s_in(s0),
    .expect_map(exp0), .busy(busy0), .done(done0), .map(map0), .ones(ones0),
    .match(match0)
  );

  f_sweep_ctrl #(.SETTLE(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abcd(abcd1), .s_in(s1),
    .expect_map(exp1), .busy(busy1), .done(done1), .map(map1), .ones(ones1),
    .match(match1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // SETTLE=1 sweep: cycle k after the accept edge; vector v occupies cycles 2v+1, 2v+2.
  task automatic sweep0(input logic [15:0] tbl, input logic [15:0] expm,
                        input bit glitch, input bit extra, input int rst_at);
    bit seen_done;
    tbl0 = tbl;
    exp0 = expm;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      if (k == rst_at) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_abcd", abcd0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_map", map0, 0);
        chk("rst_ones", ones0, 0);
        chk("rst_done", done0, 0);
        seen_done = 1'b0;
        for (int j = 0; j < 40; j++) begin
          @(posedge clk); #1;
          if (done0) seen_done = 1'b1;
        end
        chk("rst_no_done", seen_done, 0);
        return;
      end
      chk("s1_abcd", abcd0, (k <= 32) ? (k - 1) / 2 : 15);
      chk("s1_busy", busy0, 1);
      chk("s1_done", done0, (k == 33));
      glitch0 = glitch && (k % 2 == 1) && ($urandom_range(1) == 1);
      junk0   = 1'($urandom_range(1));
      start0  = extra && (k == 5 || k == 20 || k == 33);
      @(posedge clk); #1;
      glitch0 = 1'b0;
      start0  = 1'b0;
    end
    chk("s1_map", map0, tbl);
    chk("s1_ones", ones0, $countones(tbl));
    chk("s1_match", match0, (tbl == expm));
    chk("s1_busy_end", busy0, 0);
    chk("s1_done_end", done0, 0);
  endtask

  // SETTLE=0 sweep: vector v occupies cycle v+1, done in cycle 17.
  task automatic sweep1(input logic [15:0] tbl, input logic [15:0] expm);
    tbl1 = tbl;
    exp1 = expm;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      chk("s0_abcd", abcd1, (k <= 16) ? k - 1 : 15);
      chk("s0_busy", busy1, 1);
      chk("s0_done", done1, (k == 17));
      @(posedge clk); #1;
    end
    chk("s0_map", map1, tbl);
    chk("s0_ones", ones1, $countones(tbl));
    chk("s0_match", match1, (tbl == expm));
    chk("s0_busy_end", busy1, 0);
  endtask

  initial begin
    logic [15:0] t, e;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    glitch0 = 1'b0; junk0 = 1'b0;
    tbl0 = F_REF_MAP; tbl1 = '0; exp0 = '0; exp1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_abcd", abcd0, 0);
    chk("reset_busy", busy0, 0);
    chk("reset_done", done0, 0);
    chk("reset_map", map0, 0);
    chk("reset_ones", ones0, 0);
    chk("reset_match", match0, 0);
    chk("reset_abcd_s0", abcd1, 0);
    chk("reset_busy_s0", busy1, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    sweep0(F_REF_MAP, F_REF_MAP, 1'b0, 1'b0, 0);
    sweep0(F_REF_MAP, 16'h212E, 1'b0, 1'b0, 0);
    sweep1(16'hFFFF, 16'hFFFF);
    sweep1(16'h0000, 16'h0000);
    sweep0(F_REF_MAP, F_REF_MAP, 1'b0, 1'b1, 0);
    sweep0(F_REF_MAP, F_REF_MAP, 1'b0, 1'b0, 10);
    sweep0(F_REF_MAP, F_REF_MAP, 1'b0, 1'b0, 0);
    sweep0(F_REF_MAP, F_REF_MAP, 1'b1, 1'b0, 0);

    for (int n = 0; n < 6; n++) begin
      t = 16'($urandom);
      e = ($urandom_range(1) == 1) ? t : t ^ (16'h1 << $urandom_range(15));
      sweep0(t, e, 1'b1, ($urandom_range(1) == 1), 0);
      t = 16'($urandom);
      e = ($urandom_range(1) == 1) ? t : ~t;
      sweep1(t, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
